// File: rtl/pc_sequencer.sv
// Program counter and run control (IDLE/RUN/PAUSE/HALT) for the single-cycle core.
// Latency: cpu_en is combinational, so a commit happens at the same edge; pc, state, count and cause are registered.
// Backpressure: none; pause and step throttle commits, and HALT stops them until start.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] END_PC      = 32'hFFFF_FFFC,
    parameter int          COUNT_W     = 32,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pause,
    input  logic               step,
    input  logic [31:0]        next_pc,
    output logic [31:0]        pc,
    output logic               cpu_en,
    output logic               halted,
    output logic [1:0]         run_state,
    output logic [COUNT_W-1:0] instr_count,
    output logic [1:0]         halt_cause
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_LOOP  = 2'b01;
    localparam logic [1:0] CAUSE_END   = 2'b10;
    localparam logic [1:0] CAUSE_ALIGN = 2'b11;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [1:0]         cause_q, cause_d;
    logic               commit;

    // Commit enable: every RUN cycle, or a PAUSE cycle with step held.
    assign commit = rst_n & ((state_q == ST_RUN) | ((state_q == ST_PAUSE) & step));

    // Next-state logic: halt checks on a commit take priority over all run-control inputs.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        cause_d = cause_q;
        if (commit) begin
            // Retired count saturates rather than wrapping.
            if (count_q != {COUNT_W{1'b1}}) begin
                count_d = count_q + 1'b1;
            end
            if (ALIGN_CHECK && (next_pc[1:0] != 2'b00)) begin
                state_d = ST_HALT;
                cause_d = CAUSE_ALIGN;
            end else if (next_pc == pc_q) begin
                state_d = ST_HALT;
                cause_d = CAUSE_LOOP;
            end else if (pc_q == END_PC) begin
                pc_d    = next_pc;
                state_d = ST_HALT;
                cause_d = CAUSE_END;
            end else begin
                pc_d = next_pc;
                if ((state_q == ST_RUN) && pause) begin
                    state_d = ST_PAUSE;
                end else if ((state_q == ST_PAUSE) && start) begin
                    state_d = ST_RUN;
                end
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        count_d = '0;
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_HALT: begin
                    // Restart reloads the program from the top.
                    if (start) begin
                        state_d = ST_RUN;
                        pc_d    = RESET_PC;
                        count_d = '0;
                        cause_d = CAUSE_NONE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            count_q <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            cause_q <= cause_d;
        end
    end

    assign pc          = pc_q;
    assign cpu_en      = commit;
    assign run_state   = state_q;
    assign halted      = (state_q == ST_HALT);
    assign instr_count = count_q;
    assign halt_cause  = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n, start, pause, step;
    logic [31:0] next_pc, pc;
    logic        cpu_en, halted;
    logic [1:0]  run_state, halt_cause;
    logic [31:0] instr_count;

    // Second instance: END_PC=0x10, 3-bit counter, fed by a small core model.
    logic        rst2_n, start2, mode2;
    logic [31:0] next_pc2, pc2;
    logic        cpu_en2, halted2;
    logic [1:0]  run_state2, halt_cause2;
    logic [2:0]  instr_count2;

    int n_cmp = 0;
    int n_bad = 0;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .step(step),
        .next_pc(next_pc), .pc(pc), .cpu_en(cpu_en), .halted(halted),
        .run_state(run_state), .instr_count(instr_count), .halt_cause(halt_cause)
    );

    pc_sequencer #(.END_PC(32'h10), .COUNT_W(3)) dut_e (
        .clk(clk), .rst_n(rst2_n), .start(start2), .pause(1'b0), .step(1'b0),
        .next_pc(next_pc2), .pc(pc2), .cpu_en(cpu_en2), .halted(halted2),
        .run_state(run_state2), .instr_count(instr_count2), .halt_cause(halt_cause2)
    );

    // mode2=0: sequential PC+4; mode2=1: bounce between 0 and 4.
    assign next_pc2 = mode2 ? ((pc2 == 32'h0) ? 32'h4 : 32'h0) : (pc2 + 32'h4);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, start, pause, step;
        logic [31:0] npc;
        logic        en;
        logic [31:0] pc;
        logic [1:0]  st;
        logic [31:0] cnt;
        logic [1:0]  cause;
    } vec_t;

    vec_t v[33];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic p, input logic t,
                                input logic [31:0] n, input logic e, input logic [31:0] q,
                                input logic [1:0] st, input logic [31:0] c, input logic [1:0] ca);
        vec_t x;
        x.rst_n = r; x.start = s; x.pause = p; x.step = t; x.npc = n;
        x.en = e; x.pc = q; x.st = st; x.cnt = c; x.cause = ca;
        return x;
    endfunction

    task automatic tick2(input string tag, input logic [31:0] epc, input logic [1:0] est,
                         input logic [31:0] ecnt, input logic [1:0] ecause);
        @(posedge clk); #1;
        chk({tag, ".pc"}, pc2, epc);
        chk({tag, ".state"}, {30'd0, run_state2}, {30'd0, est});
        chk({tag, ".count"}, {29'd0, instr_count2}, ecnt);
        chk({tag, ".cause"}, {30'd0, halt_cause2}, {30'd0, ecause});
        @(negedge clk);
    endtask

    initial begin
        // rst start pause step next_pc | en pc state count cause
        v[0]  = mk(0,1,0,0,32'h40, 0,32'h00,2'b00,0,2'b00); // T1 reset with start
        v[1]  = mk(0,1,0,0,32'h40, 0,32'h00,2'b00,0,2'b00);
        v[2]  = mk(1,1,0,0,32'h00, 0,32'h00,2'b01,0,2'b00); // T2 IDLE->RUN, no commit
        v[3]  = mk(1,0,0,0,32'h04, 1,32'h04,2'b01,1,2'b00);
        v[4]  = mk(1,0,0,0,32'h08, 1,32'h08,2'b01,2,2'b00);
        v[5]  = mk(1,0,0,0,32'h0C, 1,32'h0C,2'b01,3,2'b00);
        v[6]  = mk(1,0,0,0,32'h10, 1,32'h10,2'b01,4,2'b00);
        v[7]  = mk(1,0,0,0,32'h14, 1,32'h14,2'b01,5,2'b00);
        v[8]  = mk(0,0,0,0,32'h00, 0,32'h00,2'b00,0,2'b00); // T3 fresh run
        v[9]  = mk(1,1,0,0,32'h00, 0,32'h00,2'b01,0,2'b00);
        v[10] = mk(1,0,0,0,32'h04, 1,32'h04,2'b01,1,2'b00);
        v[11] = mk(1,0,0,0,32'h08, 1,32'h08,2'b01,2,2'b00);
        v[12] = mk(1,0,1,0,32'h0C, 1,32'h0C,2'b10,3,2'b00); // pause at pc=8 still commits
        v[13] = mk(1,0,0,0,32'h44, 0,32'h0C,2'b10,3,2'b00);
        v[14] = mk(1,0,0,0,32'h44, 0,32'h0C,2'b10,3,2'b00);
        v[15] = mk(1,0,0,0,32'h44, 0,32'h0C,2'b10,3,2'b00);
        v[16] = mk(1,0,0,1,32'h10, 1,32'h10,2'b10,4,2'b00); // single step
        v[17] = mk(1,0,1,0,32'h55, 0,32'h10,2'b10,4,2'b00); // pause ignored in PAUSE
        v[18] = mk(1,0,0,1,32'h14, 1,32'h14,2'b10,5,2'b00); // step held
        v[19] = mk(1,0,0,1,32'h18, 1,32'h18,2'b10,6,2'b00);
        v[20] = mk(1,1,0,1,32'h1C, 1,32'h1C,2'b01,7,2'b00); // step&start -> RUN
        v[21] = mk(1,0,0,0,32'h20, 1,32'h20,2'b01,8,2'b00);
        v[22] = mk(1,0,0,0,32'h20, 1,32'h20,2'b11,9,2'b01); // T4 self-loop
        v[23] = mk(1,0,1,1,32'h30, 0,32'h20,2'b11,9,2'b01); // HALT ignores pause/step
        v[24] = mk(1,1,0,0,32'h30, 0,32'h00,2'b01,0,2'b00); // restart
        v[25] = mk(1,0,0,0,32'h04, 1,32'h04,2'b01,1,2'b00);
        v[26] = mk(1,0,1,0,32'h1A, 1,32'h04,2'b11,2,2'b11); // T5 misaligned beats pause
        v[27] = mk(1,1,0,0,32'h00, 0,32'h00,2'b01,0,2'b00);
        v[28] = mk(1,0,1,0,32'h04, 1,32'h04,2'b10,1,2'b00);
        v[29] = mk(1,1,0,0,32'h99, 0,32'h04,2'b01,1,2'b00); // start alone in PAUSE
        v[30] = mk(1,0,0,0,32'h08, 1,32'h08,2'b01,2,2'b00);
        v[31] = mk(0,1,1,1,32'h0C, 0,32'h00,2'b00,0,2'b00); // T6 reset mid-RUN
        v[32] = mk(1,0,0,0,32'h0C, 0,32'h00,2'b00,0,2'b00); // IDLE without start

        rst_n = 0; start = 0; pause = 0; step = 0; next_pc = 0;
        rst2_n = 0; start2 = 0; mode2 = 0;
        @(negedge clk);

        for (int i = 0; i < 33; i++) begin
            rst_n = v[i].rst_n; start = v[i].start; pause = v[i].pause;
            step = v[i].step; next_pc = v[i].npc;
            #1;
            chk($sformatf("v%0d.cpu_en", i), {31'd0, cpu_en}, {31'd0, v[i].en});
            @(posedge clk); #1;
            chk($sformatf("v%0d.pc", i), pc, v[i].pc);
            chk($sformatf("v%0d.state", i), {30'd0, run_state}, {30'd0, v[i].st});
            chk($sformatf("v%0d.count", i), instr_count, v[i].cnt);
            chk($sformatf("v%0d.cause", i), {30'd0, halt_cause}, {30'd0, v[i].cause});
            chk($sformatf("v%0d.halted", i), {31'd0, halted}, {31'd0, (v[i].st == 2'b11)});
            @(negedge clk);
        end

        // END_PC reached on the second instance: commits at 0,4,8,C,10; the last halts.
        rst2_n = 0;
        tick2("e.rst", 32'h0, 2'b00, 0, 2'b00);
        rst2_n = 1; start2 = 1;
        tick2("e.start", 32'h0, 2'b01, 0, 2'b00);
        start2 = 0;
        for (int i = 1; i <= 4; i++) begin
            tick2($sformatf("e.run%0d", i), 32'(i * 4), 2'b01, 32'(i), 2'b00);
        end
        tick2("e.end", 32'h14, 2'b11, 5, 2'b10);
        chk("e.halted", {31'd0, halted2}, 32'd1);
        chk("e.cpu_en_halt", {31'd0, cpu_en2}, 32'd0);

        // Counter saturation: restart, then bounce 0<->4 for nine commits.
        start2 = 1;
        tick2("e.restart", 32'h0, 2'b01, 0, 2'b00);
        start2 = 0; mode2 = 1;
        for (int i = 1; i <= 9; i++) begin
            tick2($sformatf("e.sat%0d", i), (i % 2 == 1) ? 32'h4 : 32'h0, 2'b01,
                  (i > 7) ? 32'd7 : 32'(i), 2'b00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
